// File: rtl/coeff_bank.sv
// Multi-channel coefficient store with a zero-fill sweep, range-checked writes
// and registered, read-before-write per-channel read ports.
module coeff_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int NCH    = 2,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  Sclk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [NCH*ADDR_W-1:0] rd_addr,
    output logic [NCH*DATA_W-1:0] rd_data,
    output logic                  busy,
    output logic [NCH-1:0]        loaded,
    output logic                  wr_drop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_sweep;
    logic              r_busy;
    logic              r_wr_drop;
    logic [NCH-1:0]    r_loaded;

    logic              w_start;
    logic              w_wr_ok;
    logic              w_wr_drop;
    logic              w_rd_zero;
    logic              w_last_sweep;
    logic [NCH-1:0]    w_load_set;

    // Decode sweep start, write acceptance and the loaded-flag set mask.
    always_comb begin
        w_start      = (r_state == ST_IDLE) && clear;
        w_wr_ok      = wr_en && (r_state == ST_IDLE) && !clear &&
                       (32'(wr_ch) < NCH) && (32'(wr_addr) < DEPTH);
        w_wr_drop    = wr_en && !w_wr_ok;
        // The exit edge also reads zero so no half-swept word escapes.
        w_rd_zero    = w_start || (r_state == ST_CLEAR);
        w_last_sweep = (r_sweep == LAST_ADDR);
        w_load_set   = '0;
        for (int c = 0; c < NCH; c++) begin
            w_load_set[c] = w_wr_ok && (wr_addr == LAST_ADDR) && (32'(wr_ch) == c);
        end
    end

    // Control FSM: sweep counter, busy, loaded flags and the drop pulse.
    always_ff @(posedge Sclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_sweep   <= '0;
            r_busy    <= 1'b0;
            r_loaded  <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_wr_drop;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_CLEAR;
                        r_sweep  <= '0;
                        r_busy   <= 1'b1;
                        r_loaded <= '0;
                    end else begin
                        r_loaded <= r_loaded | w_load_set;
                    end
                end
                ST_CLEAR: begin
                    if (w_last_sweep) begin
                        r_state <= ST_IDLE;
                        r_sweep <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sweep <= r_sweep + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sweep <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_rd;
        logic [ADDR_W-1:0] w_rd_addr;
        logic              w_wr_sel;

        assign w_rd_addr = rd_addr[c*ADDR_W +: ADDR_W];
        assign w_wr_sel  = w_wr_ok && (32'(wr_ch) == c);

        // Storage has no reset; only the sweep or explicit writes define it.
        always_ff @(posedge Sclk) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_sweep] <= '0;
            end else if (w_wr_sel) begin
                r_mem[wr_addr] <= wr_data;
            end
        end

        // Registered read port returning pre-write data.
        always_ff @(posedge Sclk or negedge reset_n) begin
            if (!reset_n) begin
                r_rd <= '0;
            end else if (w_rd_zero || (32'(w_rd_addr) >= DEPTH)) begin
                r_rd <= '0;
            end else begin
                r_rd <= r_mem[w_rd_addr];
            end
        end

        assign rd_data[c*DATA_W +: DATA_W] = r_rd;
    end

    assign busy    = r_busy;
    assign loaded  = r_loaded;
    assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_coeff_bank.sv
// Directed bench for coeff_bank: a vector table for the write/read path plus
// hand sequences for sweeps, drops, async reset and a small odd-sized instance.
module tb_coeff_bank;

    logic        Sclk    = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear   = 1'b0;
    logic        wr_en   = 1'b0;
    logic        wr_ch   = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [17:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic [1:0]  loaded;
    logic        wr_drop;

    logic        s_clear   = 1'b0;
    logic        s_wr_en   = 1'b0;
    logic [1:0]  s_wr_ch   = '0;
    logic [3:0]  s_wr_addr = '0;
    logic [7:0]  s_wr_data = '0;
    logic [11:0] s_rd_addr = '0;
    logic [23:0] s_rd_data;
    logic        s_busy;
    logic [2:0]  s_loaded;
    logic        s_wr_drop;

    int n_tests = 0;
    int n_fail  = 0;

    coeff_bank u_dut (
        .Sclk(Sclk), .reset_n(reset_n), .clear(clear), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .loaded(loaded), .wr_drop(wr_drop)
    );

    coeff_bank #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .NCH(3)) u_small (
        .Sclk(Sclk), .reset_n(reset_n), .clear(s_clear), .wr_en(s_wr_en),
        .wr_ch(s_wr_ch), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .busy(s_busy), .loaded(s_loaded), .wr_drop(s_wr_drop)
    );

    always #5 Sclk = ~Sclk;

    typedef struct {
        logic        we;
        logic        ch;
        logic [8:0]  addr;
        logic [15:0] data;
        logic [8:0]  ra0;
        logic [8:0]  ra1;
        logic [31:0] exp_rd;
        logic [1:0]  exp_ld;
    } vec_t;

    vec_t vecs [10];

    task automatic tick;
        @(posedge Sclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int cnt;
        int drops;

        // Memory is all-zero after the first sweep; read data lags one edge.
        vecs[0] = '{1'b1, 1'b0, 9'd5,   16'h1234, 9'd5, 9'd5,   32'h0000_0000, 2'b00};
        vecs[1] = '{1'b1, 1'b1, 9'd5,   16'hABCD, 9'd5, 9'd5,   32'h0000_1234, 2'b00};
        vecs[2] = '{1'b0, 1'b0, 9'd0,   16'h0000, 9'd5, 9'd5,   32'hABCD_1234, 2'b00};
        vecs[3] = '{1'b1, 1'b0, 9'd7,   16'h0001, 9'd7, 9'd7,   32'h0000_0000, 2'b00};
        vecs[4] = '{1'b1, 1'b0, 9'd7,   16'h0002, 9'd7, 9'd7,   32'h0000_0001, 2'b00};
        vecs[5] = '{1'b0, 1'b0, 9'd0,   16'h0000, 9'd7, 9'd7,   32'h0000_0002, 2'b00};
        vecs[6] = '{1'b1, 1'b1, 9'd511, 16'hBEEF, 9'd0, 9'd511, 32'h0000_0000, 2'b10};
        vecs[7] = '{1'b1, 1'b0, 9'd0,   16'h5555, 9'd0, 9'd511, 32'hBEEF_0000, 2'b10};
        vecs[8] = '{1'b0, 1'b0, 9'd0,   16'h0000, 9'd0, 9'd511, 32'hBEEF_5555, 2'b10};
        vecs[9] = '{1'b1, 1'b0, 9'd511, 16'h0F0F, 9'd5, 9'd7,   32'h0000_1234, 2'b11};

        // Reset state
        repeat (3) @(posedge Sclk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_loaded", {30'd0, loaded}, 32'd0);
        chk("rst_drop", {31'd0, wr_drop}, 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        reset_n = 1'b1;
        tick;
        chk("rel_busy", {31'd0, busy}, 32'd0);

        // First sweep: busy for exactly DEPTH cycles, reads forced to zero
        clear   = 1'b1;
        rd_addr = {9'd300, 9'd10};
        tick;
        clear = 1'b0;
        cnt   = 0;
        while (busy && cnt < 600) begin
            cnt++;
            if (cnt == 300) chk("busy_rd_zero", rd_data, 32'd0);
            tick;
        end
        chk("sweep_len", cnt, 32'd512);
        rd_addr = {9'd511, 9'd0};
        tick;
        chk("clr_rd_a", rd_data, 32'd0);
        rd_addr = {9'd200, 9'd511};
        tick;
        chk("clr_rd_b", rd_data, 32'd0);

        foreach (vecs[i]) begin
            wr_en   = vecs[i].we;
            wr_ch   = vecs[i].ch;
            wr_addr = vecs[i].addr;
            wr_data = vecs[i].data;
            rd_addr = {vecs[i].ra1, vecs[i].ra0};
            tick;
            chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
            chk($sformatf("vec%0d_drop", i), {31'd0, wr_drop}, 32'd0);
            chk($sformatf("vec%0d_loaded", i), {30'd0, loaded}, {30'd0, vecs[i].exp_ld});
        end
        wr_en = 1'b0;

        // Sweep with an ignored re-clear at cycle 50 and a write at cycle 100
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clr_loaded", {30'd0, loaded}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        cnt   = 0;
        drops = 0;
        while (busy && cnt < 600) begin
            cnt++;
            clear   = (cnt == 50);
            wr_en   = (cnt == 100);
            wr_ch   = 1'b0;
            wr_addr = 9'd5;
            wr_data = 16'h7777;
            tick;
            if (wr_drop) drops++;
        end
        clear = 1'b0;
        wr_en = 1'b0;
        chk("sweep2_len", cnt, 32'd512);
        chk("sweep2_drops", drops, 32'd1);
        rd_addr = {9'd511, 9'd5};
        tick;
        chk("sweep2_rd_a", rd_data, 32'd0);
        rd_addr = {9'd5, 9'd511};
        tick;
        chk("sweep2_rd_b", rd_data, 32'd0);

        // Clear and write in the same cycle: clear wins, write dropped
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 1'b1;
        wr_addr = 9'd9;
        wr_data = 16'h9999;
        tick;
        clear = 1'b0;
        wr_en = 1'b0;
        chk("clrwr_drop", {31'd0, wr_drop}, 32'd1);
        chk("clrwr_busy", {31'd0, busy}, 32'd1);
        tick;
        chk("drop_one_cycle", {31'd0, wr_drop}, 32'd0);
        cnt = 0;
        while (busy && cnt < 600) begin
            cnt++;
            tick;
        end
        chk("sweep3_done", {31'd0, busy}, 32'd0);
        rd_addr = {9'd9, 9'd9};
        tick;
        chk("clrwr_rd", rd_data, 32'd0);

        // Async reset while idle with live read data and a loaded flag
        wr_en   = 1'b1;
        wr_ch   = 1'b0;
        wr_addr = 9'd3;
        wr_data = 16'h4242;
        tick;
        wr_ch   = 1'b1;
        wr_addr = 9'd511;
        wr_data = 16'h1111;
        rd_addr = {9'd0, 9'd3};
        tick;
        wr_en = 1'b0;
        chk("pre_rst_rd", rd_data, 32'h0000_4242);
        chk("pre_rst_loaded", {30'd0, loaded}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd", rd_data, 32'd0);
        chk("async_loaded", {30'd0, loaded}, 32'd0);
        repeat (2) @(posedge Sclk);
        #2 reset_n = 1'b1;
        tick;

        // Reset at sweep cycle 200 aborts the sweep; a new clear runs fully
        clear = 1'b1;
        tick;
        clear = 1'b0;
        repeat (199) tick;
        chk("busy_at_200", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rd", rd_data, 32'd0);
        @(posedge Sclk);
        #2 reset_n = 1'b1;
        tick;
        chk("midrst_rel_busy", {31'd0, busy}, 32'd0);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        cnt   = 0;
        while (busy && cnt < 600) begin
            cnt++;
            tick;
        end
        chk("sweep4_len", cnt, 32'd512);
        rd_addr = {9'd511, 9'd3};
        tick;
        chk("sweep4_rd", rd_data, 32'd0);

        // Odd-sized instance: out-of-range channel/address writes and reads
        s_clear = 1'b1;
        tick;
        s_clear = 1'b0;
        cnt     = 0;
        while (s_busy && cnt < 100) begin
            cnt++;
            tick;
        end
        chk("s_sweep_len", cnt, 32'd12);
        s_wr_en   = 1'b1;
        s_wr_ch   = 2'd2;
        s_wr_addr = 4'd11;
        s_wr_data = 8'hA5;
        tick;
        chk("s_last_drop", {31'd0, s_wr_drop}, 32'd0);
        chk("s_loaded", {29'd0, s_loaded}, 32'd4);
        s_wr_ch   = 2'd3;
        s_wr_addr = 4'd0;
        s_wr_data = 8'h77;
        tick;
        chk("s_badch_drop", {31'd0, s_wr_drop}, 32'd1);
        s_wr_ch   = 2'd0;
        s_wr_addr = 4'd12;
        s_wr_data = 8'h66;
        tick;
        chk("s_badaddr_drop", {31'd0, s_wr_drop}, 32'd1);
        s_wr_ch   = 2'd1;
        s_wr_addr = 4'd3;
        s_wr_data = 8'h3C;
        tick;
        chk("s_ok_drop", {31'd0, s_wr_drop}, 32'd0);
        s_wr_en   = 1'b0;
        s_rd_addr = {4'd11, 4'd3, 4'd0};
        tick;
        chk("s_rd", {8'd0, s_rd_data}, 32'h00A5_3C00);
        chk("s_loaded_hold", {29'd0, s_loaded}, 32'd4);
        s_rd_addr = {4'd0, 4'd15, 4'd12};
        tick;
        chk("s_rd_oob", {8'd0, s_rd_data}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
